// File: rtl/moving_avg_filter.sv
// Stereo boxcar (moving-average) filter over the last 2**LOG2_DEPTH sample pairs.
// Latency: result registered on the accepting edge, visible one cycle later.
// Backpressure: single output stage; in_ready = !out_valid || out_ready.
module moving_avg_filter #(
  parameter int WIDTH      = 24,
  parameter int LOG2_DEPTH = 3
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_left,
  input  logic [WIDTH-1:0] in_right,
  output logic             in_ready,
  input  logic             bypass,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_left,
  output logic [WIDTH-1:0] out_right,
  input  logic             out_ready,
  output logic             primed
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int SW    = WIDTH + LOG2_DEPTH;
  localparam logic [LOG2_DEPTH:0] FILL_MAX = (LOG2_DEPTH + 1)'(DEPTH);

  // Window storage and running sums, one per channel, sharing a write pointer.
  logic [WIDTH-1:0]      buf_l_q [DEPTH];
  logic [WIDTH-1:0]      buf_r_q [DEPTH];
  logic [SW-1:0]         sum_l_q, sum_r_q;
  logic [SW-1:0]         sum_l_d, sum_r_d;
  logic [LOG2_DEPTH-1:0] wptr_q;
  logic [LOG2_DEPTH:0]   fill_q;

  logic             out_valid_q;
  logic [WIDTH-1:0] out_left_q, out_right_q;
  logic [WIDTH-1:0] out_left_d, out_right_d;
  logic             primed_q;
  logic             accept;

  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_left  = out_left_q;
  assign out_right = out_right_q;
  assign primed    = primed_q;

  // Updated sums and the filtered result (sum >>> LOG2_DEPTH, truncated to WIDTH).
  always_comb begin
    sum_l_d = sum_l_q + {{LOG2_DEPTH{in_left[WIDTH-1]}}, in_left}
                      - {{LOG2_DEPTH{buf_l_q[wptr_q][WIDTH-1]}}, buf_l_q[wptr_q]};
    sum_r_d = sum_r_q + {{LOG2_DEPTH{in_right[WIDTH-1]}}, in_right}
                      - {{LOG2_DEPTH{buf_r_q[wptr_q][WIDTH-1]}}, buf_r_q[wptr_q]};
    // The average of WIDTH-bit values always fits in WIDTH bits, so dropping the
    // low LOG2_DEPTH bits of the sum is exactly a floor-shift with no overflow.
    out_left_d  = sum_l_d[SW-1:LOG2_DEPTH];
    out_right_d = sum_r_d[SW-1:LOG2_DEPTH];
    if (bypass) begin
      out_left_d  = in_left;
      out_right_d = in_right;
    end
  end

  // Window, sum, pointer and fill-count update on every accepted sample pair.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        buf_l_q[i] <= '0;
        buf_r_q[i] <= '0;
      end
      sum_l_q  <= '0;
      sum_r_q  <= '0;
      wptr_q   <= '0;
      fill_q   <= '0;
      primed_q <= 1'b0;
    end else if (accept) begin
      buf_l_q[wptr_q] <= in_left;
      buf_r_q[wptr_q] <= in_right;
      sum_l_q         <= sum_l_d;
      sum_r_q         <= sum_r_d;
      wptr_q          <= wptr_q + LOG2_DEPTH'(1);
      if (fill_q != FILL_MAX) begin
        fill_q <= fill_q + (LOG2_DEPTH + 1)'(1);
      end
      if (fill_q == FILL_MAX - (LOG2_DEPTH + 1)'(1)) begin
        primed_q <= 1'b1;
      end
    end
  end

  // Output register: load on accept, drop valid when consumed, otherwise hold.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_left_q  <= '0;
      out_right_q <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_left_q  <= out_left_d;
      out_right_q <= out_right_d;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_moving_avg_filter.sv
// Directed bench for moving_avg_filter (WIDTH=24, DEPTH=8).
// Expected values are hand-computed window averages.
// Drives on the falling edge, samples 1 time unit after the rising edge.
module tb_moving_avg_filter;

  logic               CLOCK_50 = 1'b0;
  logic               reset = 1'b1;
  logic               in_valid = 1'b0;
  logic signed [23:0] in_left = '0;
  logic signed [23:0] in_right = '0;
  logic               in_ready;
  logic               bypass = 1'b0;
  logic               out_valid;
  logic signed [23:0] out_left;
  logic signed [23:0] out_right;
  logic               out_ready = 1'b1;
  logic               primed;

  int checks = 0;
  int errors = 0;

  moving_avg_filter #(.WIDTH(24), .LOG2_DEPTH(3)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .in_valid (in_valid),
    .in_left  (in_left),
    .in_right (in_right),
    .in_ready (in_ready),
    .bypass   (bypass),
    .out_valid(out_valid),
    .out_left (out_left),
    .out_right(out_right),
    .out_ready(out_ready),
    .primed   (primed)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Two-cycle reset pulse; optionally presents a sample during reset.
  task automatic do_reset(input logic with_sample);
    @(negedge CLOCK_50);
    reset    = 1'b1;
    in_valid = with_sample;
    in_left  = 24'sd800;
    in_right = -24'sd800;
    @(posedge CLOCK_50); #1;
    chk("rst_in_ready", in_ready, 1);
    @(posedge CLOCK_50); #1;
    @(negedge CLOCK_50);
    reset    = 1'b0;
    in_valid = 1'b0;
  endtask

  // One accepted sample pair (out_ready assumed high or out_valid low).
  task automatic send(input logic signed [23:0] l, input logic signed [23:0] r,
                      input logic byp);
    @(negedge CLOCK_50);
    in_valid = 1'b1;
    in_left  = l;
    in_right = r;
    bypass   = byp;
    @(posedge CLOCK_50); #1;
    in_valid = 1'b0;
    bypass   = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset(1'b0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_primed", primed, 0);
    chk("reset_out_left", out_left, 0);
    chk("reset_out_right", out_right, 0);
    chk("reset_in_ready", in_ready, 1);

    // Step response: 100..800 then 800; primed rises with the 8th output
    for (int k = 1; k <= 9; k++) begin
      send(24'sd800, -24'sd800, 1'b0);
      chk("step_left", out_left, (k > 8 ? 8 : k) * 100);
      chk("step_right", out_right, -(k > 8 ? 8 : k) * 100);
      chk("step_primed", primed, (k >= 8) ? 1 : 0);
      chk("step_valid", out_valid, 1);
    end

    // Impulse -1: floor keeps -1 for 8 outputs, then 0
    do_reset(1'b0);
    send(-24'sd1, 24'sd0, 1'b0);
    chk("imp_neg_0", out_left, -1);
    for (int k = 1; k <= 8; k++) begin
      send(24'sd0, 24'sd0, 1'b0);
      chk("imp_neg", out_left, (k < 8) ? -1 : 0);
    end

    // Impulse 7: floor(7/8)=0 throughout
    do_reset(1'b0);
    send(24'sd7, 24'sd7, 1'b0);
    chk("imp_pos_0", out_left, 0);
    for (int k = 0; k < 3; k++) begin
      send(24'sd0, 24'sd0, 1'b0);
      chk("imp_pos", out_left, 0);
    end

    // Backpressure: one output held for 5 cycles, then next sample accepted
    do_reset(1'b0);
    out_ready = 1'b0;
    send(24'sd800, 24'sd0, 1'b0);
    chk("bp_first", out_left, 100);
    @(negedge CLOCK_50);
    in_valid = 1'b1;
    in_left  = 24'sd1600;
    in_right = 24'sd0;
    for (int k = 0; k < 5; k++) begin
      @(posedge CLOCK_50); #1;
      chk("bp_in_ready", in_ready, 0);
      chk("bp_hold_left", out_left, 100);
      chk("bp_hold_valid", out_valid, 1);
    end
    @(negedge CLOCK_50);
    out_ready = 1'b1;
    @(posedge CLOCK_50); #1;
    in_valid = 1'b0;
    chk("bp_release_left", out_left, 300);
    chk("bp_release_valid", out_valid, 1);
    @(posedge CLOCK_50); #1;
    chk("bp_drain_valid", out_valid, 0);
    chk("bp_drain_hold", out_left, 300);

    // Bypass: window keeps updating underneath
    do_reset(1'b0);
    for (int k = 0; k < 8; k++) send(24'sd800, 24'sd800, 1'b0);
    chk("byp_window", out_left, 800);
    send(24'sd0, 24'sd0, 1'b1);
    chk("byp_on_left", out_left, 0);
    chk("byp_on_right", out_right, 0);
    send(24'sd0, 24'sd0, 1'b0);
    chk("byp_off_left", out_left, 600);
    chk("byp_off_right", out_right, 600);

    // Reset mid-stream (sample presented during reset must be discarded)
    do_reset(1'b0);
    for (int k = 0; k < 5; k++) send(24'sd800, 24'sd800, 1'b0);
    chk("mid_pre", out_left, 500);
    do_reset(1'b1);
    chk("mid_rst_left", out_left, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_primed", primed, 0);
    send(24'sd800, -24'sd800, 1'b0);
    chk("mid_next_left", out_left, 100);
    chk("mid_next_right", out_right, -100);

    // Extremes: no wrap at full scale
    do_reset(1'b0);
    for (int k = 0; k < 8; k++) send(-24'sd8388608, 24'sd8388607, 1'b0);
    chk("ext_min_left", out_left, -8388608);
    chk("ext_max_right", out_right, 8388607);
    do_reset(1'b0);
    for (int k = 0; k < 8; k++) send(24'sd8388607, -24'sd8388608, 1'b0);
    chk("ext_max_left", out_left, 8388607);
    chk("ext_min_right", out_right, -8388608);
    chk("ext_primed", primed, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
